// File: rtl/cv32e40p_pkg.sv
// Shared constants for the cv32e40p interrupt generator: irq mask, register map
// and TIMER_CTRL field layout.
package cv32e40p_pkg;

    // Lines the core actually implements: software/timer/external (3,7,11) and fast irqs 16-31.
    localparam logic [31:0] IRQ_MASK = 32'hFFFF_0888;

    typedef enum logic [3:0] {
        IRQGEN_ENABLE     = 4'h0,
        IRQGEN_PENDING    = 4'h1,
        IRQGEN_CLEAR      = 4'h2,
        IRQGEN_MODE       = 4'h3,
        IRQGEN_TIMER_LOAD = 4'h4,
        IRQGEN_TIMER_CTRL = 4'h5,
        IRQGEN_TIMER_CNT  = 4'h6
    } irqgen_reg_e;

    localparam int unsigned TCTRL_EN_BIT  = 0;
    localparam int unsigned TCTRL_AR_BIT  = 1;
    localparam int unsigned TCTRL_TGT_LSB = 8;
    localparam int unsigned TCTRL_TGT_W   = 5;

    typedef struct packed {
        logic                   en;
        logic                   autoreload;
        logic [TCTRL_TGT_W-1:0] target;
    } timer_ctrl_t;

    function automatic logic [31:0] pack_timer_ctrl(input timer_ctrl_t c);
        logic [31:0] w;
        w                                 = '0;
        w[TCTRL_EN_BIT]                   = c.en;
        w[TCTRL_AR_BIT]                   = c.autoreload;
        w[TCTRL_TGT_LSB +: TCTRL_TGT_W]   = c.target;
        return w;
    endfunction

endpackage

// File: rtl/cv32e40p_irq_generator_timer.sv
// Down-counting interval timer: counts TIMER_LOAD..0 and flags expiry while at zero.
module cv32e40p_irq_generator_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] load_i,
    input  logic        en_i,
    input  logic        autoreload_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic [31:0] cnt_o,
    output logic        expire_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Expiry is decided from the current state only, so a control write in the
    // same cycle cannot suppress the set it produces.
    assign expire_o = en_i && (cnt_q == 32'd0);
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = load_i;
        end else if (stop_i) begin
            cnt_d = cnt_q;
        end else if (en_i) begin
            if (cnt_q != 32'd0) begin
                cnt_d = cnt_q - 32'd1;
            end else if (autoreload_i) begin
                cnt_d = load_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cv32e40p_irq_generator.sv
// Memory-mapped interrupt generator: per-line level/latched pending logic,
// enable masking and a one-shot/periodic timer that can raise a latched line.
module cv32e40p_irq_generator #(
    parameter logic [31:0] IRQ_MASK     = cv32e40p_pkg::IRQ_MASK,
    parameter logic [31:0] RESET_ENABLE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] event_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] irq_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i
);
    import cv32e40p_pkg::*;

    logic [31:0] enable_q, enable_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] mode_q, mode_d;
    logic [31:0] event_q;
    logic [31:0] tload_q, tload_d;
    timer_ctrl_t tctrl_q, tctrl_d;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_en;
    logic        ctrl_wr;
    logic        timer_start;
    logic        timer_stop;
    logic        timer_expire;
    logic [31:0] timer_cnt;
    logic [31:0] w1s_vec, w1c_vec, ack_vec, timer_vec, edge_vec;
    logic [31:0] set_vec, clr_vec;

    assign gnt_o   = req_i;
    assign wr_en   = req_i & we_i;
    assign ctrl_wr = wr_en && (addr_i == IRQGEN_TIMER_CTRL);

    assign timer_start = ctrl_wr &&  wdata_i[TCTRL_EN_BIT];
    assign timer_stop  = ctrl_wr && !wdata_i[TCTRL_EN_BIT];

    cv32e40p_irq_generator_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (tload_q),
        .en_i         (tctrl_q.en),
        .autoreload_i (tctrl_q.autoreload),
        .start_i      (timer_start),
        .stop_i       (timer_stop),
        .cnt_o        (timer_cnt),
        .expire_o     (timer_expire)
    );

    assign w1s_vec   = (wr_en && (addr_i == IRQGEN_PENDING)) ? wdata_i : 32'd0;
    assign w1c_vec   = (wr_en && (addr_i == IRQGEN_CLEAR))   ? wdata_i : 32'd0;
    assign ack_vec   = irq_ack_i    ? (32'd1 << irq_id_i)       : 32'd0;
    assign timer_vec = timer_expire ? (32'd1 << tctrl_q.target) : 32'd0;
    assign edge_vec  = event_i & ~event_q;
    assign set_vec   = edge_vec | w1s_vec | timer_vec;
    assign clr_vec   = w1c_vec | ack_vec;

    // Level lines mirror the event; latched lines give set priority over clear.
    for (genvar gi = 0; gi < 32; gi++) begin : g_pending
        assign pending_d[gi] = !mode_q[gi]     ? event_i[gi]   :
                               set_vec[gi]     ? 1'b1          :
                               clr_vec[gi]     ? 1'b0          :
                                                 pending_q[gi];
    end

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        tload_d  = tload_q;
        tctrl_d  = tctrl_q;
        if (wr_en) begin
            case (addr_i)
                IRQGEN_ENABLE:     enable_d = wdata_i;
                IRQGEN_MODE:       mode_d   = wdata_i;
                IRQGEN_TIMER_LOAD: tload_d  = wdata_i;
                IRQGEN_TIMER_CTRL: begin
                    tctrl_d.en         = wdata_i[TCTRL_EN_BIT];
                    tctrl_d.autoreload = wdata_i[TCTRL_AR_BIT];
                    tctrl_d.target     = wdata_i[TCTRL_TGT_LSB +: TCTRL_TGT_W];
                end
                default: ;
            endcase
        end
        // One-shot expiry disarms the timer unless software rewrote CTRL this cycle.
        if (!ctrl_wr && timer_expire && !tctrl_q.autoreload) begin
            tctrl_d.en = 1'b0;
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        if (req_i && !we_i) begin
            case (addr_i)
                IRQGEN_ENABLE:     rdata_d = enable_q;
                IRQGEN_PENDING:    rdata_d = pending_q;
                IRQGEN_MODE:       rdata_d = mode_q;
                IRQGEN_TIMER_LOAD: rdata_d = tload_q;
                IRQGEN_TIMER_CTRL: rdata_d = pack_timer_ctrl(tctrl_q);
                IRQGEN_TIMER_CNT:  rdata_d = timer_cnt;
                default:           rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q  <= RESET_ENABLE;
            pending_q <= '0;
            mode_q    <= '0;
            event_q   <= '0;
            tload_q   <= '0;
            tctrl_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            event_q   <= event_i;
            tload_q   <= tload_d;
            tctrl_q   <= tctrl_d;
            rvalid_q  <= req_i;
            rdata_q   <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = pending_q & enable_q & IRQ_MASK;

endmodule

// File: tb/tb_cv32e40p_irq_generator.sv
// Self-checking bench for cv32e40p_irq_generator: bus responses go through a
// scoreboard queue, irq behaviour is checked inline per scenario.
module tb_cv32e40p_irq_generator;

    localparam logic [31:0] EXP_MASK = 32'hFFFF_0888;
    localparam logic [3:0]  A_ENABLE = 4'h0;
    localparam logic [3:0]  A_PEND   = 4'h1;
    localparam logic [3:0]  A_CLEAR  = 4'h2;
    localparam logic [3:0]  A_MODE   = 4'h3;
    localparam logic [3:0]  A_LOAD   = 4'h4;
    localparam logic [3:0]  A_CTRL   = 4'h5;
    localparam logic [3:0]  A_CNT    = 4'h6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] event_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [31:0] irq_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic        exp_rvalid;
    logic [31:0] exp_pop;

    always #5 clk = ~clk;

    cv32e40p_irq_generator dut (
        .clk       (clk),
        .rst       (rst),
        .event_i   (event_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .irq_o     (irq_o),
        .irq_ack_i (irq_ack_i),
        .irq_id_i  (irq_id_i)
    );

    // A granted request must be answered exactly one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_rvalid <= 1'b0;
        else     exp_rvalid <= req_i;
    end

    always @(negedge clk) begin
        n_tests++;
        if (rvalid_o !== exp_rvalid) begin
            n_fail++;
            $display("FAIL rvalid: got %b expected %b", rvalid_o, exp_rvalid);
        end
        if (exp_rvalid) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: response with empty queue, rdata=%h", rdata_o);
            end else begin
                exp_pop = exp_q.pop_front();
                n_tests++;
                if (rdata_o !== exp_pop) begin
                    n_fail++;
                    $display("FAIL rdata: got %h expected %h", rdata_o, exp_pop);
                end else begin
                    $display("[TB] rsp rdata=%h", rdata_o);
                end
            end
        end else begin
            n_tests++;
            if (rdata_o !== 32'd0) begin
                n_fail++;
                $display("FAIL rdata_idle: got %h expected 00000000", rdata_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        exp_q.push_back(32'd0);
        $display("[TB] wr addr=%0h data=%h", a, d);
        tick();
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] e);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        exp_q.push_back(e);
        $display("[TB] rd addr=%0h expect=%h", a, e);
        tick();
        req_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_tests++;
        if (irq_o !== 32'd0 || rvalid_o !== 1'b0 || rdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%h rvalid=%b rdata=%h expected 0/0/0", irq_o, rvalid_o, rdata_o);
        end
        rst = 1'b0;
        tick();
        req_i = 1'b1; we_i = 1'b0; addr_i = A_ENABLE;
        exp_q.push_back(32'd0);
        #1;
        n_tests++;
        if (gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL gnt: got %b expected 1", gnt_o);
        end
        tick();
        req_i = 1'b0;
        #1;
        n_tests++;
        if (gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_idle: got %b expected 0", gnt_o);
        end
        bus_read(A_PEND, 32'd0);
        bus_read(A_MODE, 32'd0);
        bus_read(A_CTRL, 32'd0);
        bus_read(A_CNT,  32'd0);
        bus_read(A_LOAD, 32'd0);
    endtask

    task automatic test_latched();
        bus_write(A_MODE,   32'd1 << 11);
        bus_write(A_ENABLE, 32'd1 << 11);
        n_tests++;
        if (irq_o[11] !== 1'b0) begin n_fail++; $display("FAIL latched_idle: irq11=%b expected 0", irq_o[11]); end
        event_i[11] = 1'b1;
        tick();
        n_tests++;
        if (irq_o[11] !== 1'b1) begin n_fail++; $display("FAIL latched_edge: irq11=%b expected 1", irq_o[11]); end
        tick();
        event_i[11] = 1'b0;
        tick();
        n_tests++;
        if (irq_o[11] !== 1'b1) begin n_fail++; $display("FAIL latched_hold: irq11=%b expected 1", irq_o[11]); end
        irq_ack_i = 1'b1; irq_id_i = 5'd11;
        tick();
        irq_ack_i = 1'b0;
        n_tests++;
        if (irq_o[11] !== 1'b0) begin n_fail++; $display("FAIL latched_ack: irq11=%b expected 0", irq_o[11]); end
        event_i[11] = 1'b1;
        tick();
        event_i[11] = 1'b0;
        bus_write(A_CLEAR, 32'd1 << 11);
        n_tests++;
        if (irq_o[11] !== 1'b0) begin n_fail++; $display("FAIL latched_w1c: irq11=%b expected 0", irq_o[11]); end
        bus_read(A_PEND, 32'd0);
        bus_write(A_PEND, 32'd1 << 11);
        irq_ack_i = 1'b1; irq_id_i = 5'd5;
        tick();
        irq_ack_i = 1'b0;
        n_tests++;
        if (irq_o[11] !== 1'b1) begin n_fail++; $display("FAIL latched_other_ack: irq11=%b expected 1", irq_o[11]); end
    endtask

    task automatic test_level();
        logic prev;
        bus_write(A_ENABLE, (32'd1 << 16) | (32'd1 << 11));
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (irq_o[16] !== prev) begin
                n_fail++;
                $display("FAIL level_follow k=%0d: irq16=%b expected %b", k, irq_o[16], prev);
            end
            event_i[16] = (k < 3);
            irq_ack_i   = (k == 1);
            irq_id_i    = 5'd16;
            prev        = event_i[16];
            tick();
        end
        irq_ack_i = 1'b0;
        // Line 11 still pending from the previous scenario; drop it to level mode.
        bus_write(A_MODE, 32'd0);
        n_tests++;
        if (irq_o[11] !== 1'b1) begin n_fail++; $display("FAIL mode_switch_keep: irq11=%b expected 1", irq_o[11]); end
        tick();
        n_tests++;
        if (irq_o[11] !== 1'b0) begin n_fail++; $display("FAIL mode_switch_follow: irq11=%b expected 0", irq_o[11]); end
        bus_read(A_PEND, 32'd0);
    endtask

    task automatic test_timer();
        logic exp_irq;
        bus_write(A_MODE,   32'd1 << 7);
        bus_write(A_ENABLE, 32'd1 << 7);
        bus_write(A_LOAD,   32'd4);
        bus_write(A_CTRL,   32'h0000_0703);
        for (int k = 0; k < 10; k++) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = A_CNT;
            exp_q.push_back(32'(4 - (k % 5)));
            irq_ack_i = (k % 5 == 0) && (k > 0);
            irq_id_i  = 5'd7;
            tick();
            exp_irq = (k % 5 == 4);
            n_tests++;
            if (irq_o[7] !== exp_irq) begin
                n_fail++;
                $display("FAIL timer_period k=%0d: irq7=%b expected %b", k, irq_o[7], exp_irq);
            end
        end
        req_i = 1'b0; irq_ack_i = 1'b0;
        bus_write(A_CTRL, 32'h0000_0700);
        bus_read(A_CNT,  32'd4);
        bus_read(A_CNT,  32'd4);
        bus_read(A_CTRL, 32'h0000_0700);
        irq_ack_i = 1'b1; irq_id_i = 5'd7;
        tick();
        irq_ack_i = 1'b0;
        n_tests++;
        if (irq_o[7] !== 1'b0) begin n_fail++; $display("FAIL timer_ack: irq7=%b expected 0", irq_o[7]); end
        // One-shot countdown
        bus_write(A_LOAD, 32'd2);
        bus_write(A_CTRL, 32'h0000_0701);
        tick();
        tick();
        n_tests++;
        if (irq_o[7] !== 1'b0) begin n_fail++; $display("FAIL oneshot_early: irq7=%b expected 0", irq_o[7]); end
        tick();
        n_tests++;
        if (irq_o[7] !== 1'b1) begin n_fail++; $display("FAIL oneshot_fire: irq7=%b expected 1", irq_o[7]); end
        bus_read(A_CTRL, 32'h0000_0700);
        bus_read(A_CNT,  32'd0);
        irq_ack_i = 1'b1; irq_id_i = 5'd7;
        tick();
        irq_ack_i = 1'b0;
        // LOAD=0 periodic: expiry every cycle, set beats ack and CTRL writes
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'h0000_0703);
        bus_read(A_CNT, 32'd0);
        bus_read(A_CNT, 32'd0);
        irq_ack_i = 1'b1; irq_id_i = 5'd7;
        tick();
        irq_ack_i = 1'b0;
        n_tests++;
        if (irq_o[7] !== 1'b1) begin n_fail++; $display("FAIL timer_set_wins: irq7=%b expected 1", irq_o[7]); end
        bus_write(A_CTRL, 32'h0000_0700);
        bus_read(A_CNT, 32'd0);
        irq_ack_i = 1'b1; irq_id_i = 5'd7;
        tick();
        irq_ack_i = 1'b0;
        n_tests++;
        if (irq_o[7] !== 1'b0) begin n_fail++; $display("FAIL timer_stopped: irq7=%b expected 0", irq_o[7]); end
    endtask

    task automatic test_set_wins();
        bus_write(A_MODE,   32'd1 << 3);
        bus_write(A_ENABLE, 32'd1 << 3);
        irq_ack_i = 1'b1; irq_id_i = 5'd3;
        bus_write(A_PEND, 32'd1 << 3);
        irq_ack_i = 1'b0;
        n_tests++;
        if (irq_o[3] !== 1'b1) begin n_fail++; $display("FAIL ack_vs_w1s: irq3=%b expected 1", irq_o[3]); end
        bus_read(A_PEND, 32'h0000_0008);
        bus_write(A_CLEAR, 32'd1 << 3);
        irq_ack_i = 1'b1; irq_id_i = 5'd3;
        tick();
        irq_ack_i = 1'b0;
        bus_read(A_PEND, 32'd0);
    endtask

    task automatic test_all_latched();
        bus_write(A_MODE,   32'hFFFF_FFFF);
        bus_write(A_ENABLE, 32'hFFFF_FFFF);
        bus_write(A_PEND,   32'hFFFF_FFFF);
        n_tests++;
        if (irq_o !== EXP_MASK) begin n_fail++; $display("FAIL all_latched: irq=%h expected %h", irq_o, EXP_MASK); end
        bus_read(4'h7, 32'd0);
        bus_read(A_PEND, 32'hFFFF_FFFF);
        bus_write(4'hA, 32'h0000_1234);
        bus_read(A_ENABLE, 32'hFFFF_FFFF);
        bus_read(A_CLEAR, 32'd0);
        bus_write(A_CLEAR, 32'hFFFF_FFFF);
        n_tests++;
        if (irq_o !== 32'd0) begin n_fail++; $display("FAIL all_cleared: irq=%h expected 00000000", irq_o); end
    endtask

    task automatic test_reset_mid();
        bus_write(A_PEND, 32'd1 << 11);
        bus_write(A_LOAD, 32'd100);
        bus_write(A_CTRL, 32'h0000_0B01);
        bus_read(A_CNT, 32'd100);
        tick();
        n_tests++;
        if (irq_o[11] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: irq11=%b expected 1", irq_o[11]); end
        req_i = 1'b1; we_i = 1'b0; addr_i = A_ENABLE;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (irq_o !== 32'd0 || rvalid_o !== 1'b0 || rdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_immediate: irq=%h rvalid=%b rdata=%h expected 0/0/0", irq_o, rvalid_o, rdata_o);
        end
        tick();
        req_i = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        bus_read(A_CNT,    32'd0);
        bus_read(A_ENABLE, 32'd0);
        bus_read(A_PEND,   32'd0);
        bus_read(A_CTRL,   32'd0);
        n_tests++;
        if (irq_o !== 32'd0) begin n_fail++; $display("FAIL post_reset_irq: irq=%h expected 00000000", irq_o); end
    endtask

    initial begin
        rst = 1'b1;
        event_i = 32'd0;
        req_i = 1'b0; we_i = 1'b0; addr_i = 4'd0; wdata_i = 32'd0;
        irq_ack_i = 1'b0; irq_id_i = 5'd0;
        test_reset();
        test_latched();
        test_level();
        test_timer();
        test_set_wins();
        test_all_latched();
        test_reset_mid();
        repeat (4) tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses missing, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
